// File: rtl/bus_handshake_tx_pkg.sv
// Shared constants for the 4-phase bus handshake transmitter.
package bus_handshake_tx_pkg;

    localparam int DEFAULT_BUS_WIDTH  = 8;
    localparam int DEFAULT_NUM_STAGES = 2;

    // Accept-to-DONE cycles when the destination echoes BUS_ENABLE straight back.
    function automatic int min_latency(input int num_stages);
        return 2 * (num_stages + 1) + 2;
    endfunction

endpackage

// File: rtl/bus_handshake_tx_bit_sync.sv
// Multi-flop level synchronizer; stage 0 is the only flop that sees the async input.
module BIT_SYNC #(
    parameter int BUS_WIDTH  = 1,
    parameter int NUM_STAGES = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] D,
    output logic [BUS_WIDTH-1:0] Q
);

    logic [NUM_STAGES-1:0][BUS_WIDTH-1:0] sync_q;
    logic [NUM_STAGES-1:0][BUS_WIDTH-1:0] sync_d;

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = D;
        for (int i = 1; i < NUM_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign Q = sync_q[NUM_STAGES-1];

endmodule

// File: rtl/bus_handshake_tx.sv
// Source side of a 4-phase bus handshake: holds a word on UNSYNC_BUS and raises
// BUS_ENABLE until the synchronized acknowledge completes the full cycle.
//
//   state   | meaning
//   IDLE    | ready for a new word; DONE pulses here after a completed transfer
//   SETUP   | bus loaded, one settle cycle before the request rises
//   REQ     | BUS_ENABLE high, waiting for ack_sync=1
//   RELEASE | BUS_ENABLE low, waiting for ack_sync=0
module bus_handshake_tx
    import bus_handshake_tx_pkg::*;
#(
    parameter int BUS_WIDTH  = DEFAULT_BUS_WIDTH,
    parameter int NUM_STAGES = DEFAULT_NUM_STAGES
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] DATA_IN,
    input  logic                 DATA_VALID,
    output logic                 DATA_READY,
    input  logic                 ACK_ASYNC,
    output logic [BUS_WIDTH-1:0] UNSYNC_BUS,
    output logic                 BUS_ENABLE,
    output logic                 DONE,
    output logic                 OVERFLOW
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SETUP   = 2'd1;
    localparam logic [1:0] ST_REQ     = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        SETUP   = ST_SETUP,
        REQ     = ST_REQ,
        RELEASE = ST_RELEASE
    } state_t;

    state_t                state_q, state_d;
    logic [BUS_WIDTH-1:0]  bus_q, bus_d;
    logic                  enable_q, enable_d;
    logic                  done_q, done_d;
    logic                  overflow_q, overflow_d;
    logic                  ack_sync;

    BIT_SYNC #(
        .BUS_WIDTH  (1),
        .NUM_STAGES (NUM_STAGES)
    ) u_ack_sync (
        .CLK (CLK),
        .RST (RST),
        .D   (ACK_ASYNC),
        .Q   (ack_sync)
    );

    assign DATA_READY = (state_q == IDLE);

    always_comb begin
        state_d    = state_q;
        bus_d      = bus_q;
        overflow_d = overflow_q | (DATA_VALID & ~DATA_READY);

        case (state_q)
            IDLE: begin
                if (DATA_VALID) begin
                    bus_d   = DATA_IN;
                    state_d = SETUP;
                end
            end
            SETUP:   state_d = REQ;
            // A stale ack level seen here is taken as this transfer's acknowledge.
            REQ:     if (ack_sync)  state_d = RELEASE;
            RELEASE: if (!ack_sync) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        enable_d = (state_d == REQ);
        done_d   = (state_q == RELEASE) && (state_d == IDLE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            bus_q      <= '0;
            enable_q   <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bus_q      <= bus_d;
            enable_q   <= enable_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

    assign UNSYNC_BUS = bus_q;
    assign BUS_ENABLE = enable_q;
    assign DONE       = done_q;
    assign OVERFLOW   = overflow_q;

endmodule

// File: doc/bus_handshake_tx.md
BUS_HANDSHAKE_TX -- requirements
Module: bus_handshake_tx

Interface
REQ-001 The block SHALL have parameter BUS_WIDTH, default 8, data bus width in bits.
REQ-002 The block SHALL have parameter NUM_STAGES, default 2, number of synchronizer flops on the acknowledge path.
REQ-003 The block SHALL use a single clock, CLK; reset RST is asynchronous and active-low.
REQ-004 The block SHALL have the following ports:
- CLK  input  1  source-domain clock
- RST  input  1  async active-low reset
- DATA_IN  input  BUS_WIDTH  word to transfer
- DATA_VALID  input  1  source offers DATA_IN this cycle
- DATA_READY  output  1  block can accept a word this cycle
- ACK_ASYNC  input  1  level acknowledge from the destination domain, unsynchronized
- UNSYNC_BUS  output  BUS_WIDTH  registered bus driven to the destination synchronizer
- BUS_ENABLE  output  1  registered request level to the destination synchronizer
- DONE  output  1  one-cycle pulse on handshake completion
- OVERFLOW  output  1  sticky error flag

Function
REQ-005 ACK_ASYNC SHALL pass through a NUM_STAGES-flop synchronizer, giving ack_sync; no other logic SHALL sample ACK_ASYNC.
REQ-006 The FSM SHALL have four states: IDLE, SETUP, REQ and RELEASE.
REQ-007 DATA_READY SHALL equal 1 only in IDLE, decoded combinationally from the state register.
REQ-008 In IDLE with DATA_VALID=1, the block SHALL load DATA_IN into UNSYNC_BUS at the next edge and go to SETUP.
REQ-009 SETUP SHALL last exactly one cycle and then go to REQ, so that UNSYNC_BUS is stable for at least one full cycle before BUS_ENABLE rises.
REQ-010 In REQ, BUS_ENABLE SHALL be 1; the FSM SHALL stay in REQ until ack_sync=1 and then go to RELEASE.
REQ-011 In RELEASE, BUS_ENABLE SHALL be 0; the FSM SHALL stay in RELEASE until ack_sync=0 and then go to IDLE.
REQ-012 DONE SHALL pulse high for exactly one cycle, in the first IDLE cycle after the RELEASE-to-IDLE transition.
REQ-013 BUS_ENABLE SHALL be a flop output decoded from the next state, so it is glitch-free.
REQ-014 UNSYNC_BUS SHALL hold its value from the load until the next load, including through IDLE.
REQ-015 DATA_VALID=1 while DATA_READY=0 SHALL set OVERFLOW; that word SHALL be dropped, and the in-flight transfer and UNSYNC_BUS SHALL be unaffected.
REQ-016 OVERFLOW SHALL clear only on reset.
REQ-017 DATA_VALID=1 in the same cycle as the DONE pulse SHALL be accepted, because DATA_READY=1 in that cycle.
REQ-018 If ack_sync=1 while in IDLE or SETUP (a stale acknowledge), the FSM SHALL still advance to REQ, and in REQ it SHALL treat ack_sync=1 as the acknowledge.
REQ-019 The destination SHALL guarantee 4-phase behaviour (acknowledge low before a new request); the block SHALL NOT include a timeout.
REQ-020 Minimum transfer latency SHALL be 2*(NUM_STAGES+1)+2 cycles from DATA_VALID acceptance to DONE, when the destination echoes BUS_ENABLE back as ACK_ASYNC with zero delay.

Reset
REQ-021 RST low SHALL immediately force:
- state = IDLE
- UNSYNC_BUS = 0
- BUS_ENABLE = 0
- DONE = 0
- OVERFLOW = 0
- all synchronizer flops = 0
REQ-022 Reset asserted mid-transfer SHALL abort the transfer with no DONE pulse; after reset release, DATA_READY SHALL be 1 in the first cycle.

Structure
REQ-023 State encodings SHALL be localparams inside the module; no shared package is required.
REQ-024 The acknowledge synchronizer SHALL be the existing codebase module BIT_SYNC, instantiated with BUS_WIDTH=1 and NUM_STAGES passed through.
REQ-025 The design SHALL target 120-200 lines of RTL.

Verification
REQ-026 Single transfer: NUM_STAGES=2, loopback ACK_ASYNC=BUS_ENABLE, DATA_IN=8'hA5 for one cycle -> UNSYNC_BUS=8'hA5, BUS_ENABLE rises 2 cycles after acceptance, DONE pulses once, OVERFLOW=0.
REQ-027 Back-to-back transfers: loopback, present 8'h3C, then present 8'hC3 in the DONE cycle -> second word accepted in that cycle; two DONE pulses; UNSYNC_BUS sequence 3C then C3.
REQ-028 Overflow: present 8'h11, then 8'h22 while DATA_READY=0 -> OVERFLOW=1 and stays 1; UNSYNC_BUS stays 8'h11; one DONE pulse.
REQ-029 Slow acknowledge: ACK_ASYNC held low 20 cycles -> BUS_ENABLE stays 1 and DATA_READY stays 0 throughout; completion follows once ACK_ASYNC rises and then falls.
REQ-030 Reset in REQ: assert RST while BUS_ENABLE=1 -> BUS_ENABLE=0 and UNSYNC_BUS=0 immediately, no DONE pulse, DATA_READY=1 in the first cycle after release.
REQ-031 Destination pairing: connect to the destination bus synchronizer (NUM_STAGES=2), with ACK_ASYNC driven by the destination-side level of BUS_ENABLE -> exactly one destination enable pulse per source DONE, with matching data values.
